// File: rtl/mem_arbiter.sv
// Purpose: shares one single-ported synchronous memory between fetch (I) and load/store (D) requesters.
// Latency: grant and memory issue are combinational with the request; rvalid/rdata follow MEM_LAT+1 cycles after issue.
// Backpressure: one transaction outstanding; requests seen while busy wait ungranted with stall held high.
module mem_arbiter #(
  parameter int ADDR_W    = 14,
  parameter int MEM_LAT   = 2,
  parameter int MAX_D_RUN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              m_en,
  output logic [3:0]        m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  output logic              stall
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int RUN_W = $clog2(MAX_D_RUN + 1);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_D_RUN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [RUN_W-1:0] d_run_q, d_run_d;
  logic             owner_i_q, owner_i_d;
  logic             owner_st_q, owner_st_d;
  logic [31:0]      i_rdata_q, i_rdata_d;
  logic [31:0]      d_rdata_q, d_rdata_d;
  logic             free;
  logic             grant_i;
  logic             grant_d;

  // Only the word-address bits reach the memory; the rest are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0], d_addr[31:ADDR_W+2], d_addr[1:0]};

  // Arbitration, next-state and datapath capture; reset gates every grant so requests are ignored.
  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    d_run_d    = d_run_q;
    owner_i_d  = owner_i_q;
    owner_st_d = owner_st_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    free       = rst && (state_q != WAIT);

    if (free) begin
      if (d_req && i_req) begin
        // D normally wins, but I is forced through after MAX_D_RUN back-to-back D wins.
        if (d_run_q == RUN_MAX) grant_i = 1'b1;
        else                    grant_d = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end else if (i_req) begin
        grant_i = 1'b1;
      end
    end

    case (state_q)
      IDLE, RESP: begin
        if (grant_i || grant_d) begin
          state_d    = WAIT;
          lat_cnt_d  = LAT_INIT;
          owner_i_d  = grant_i;
          owner_st_d = grant_d && d_we;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (lat_cnt_q == '0) begin
          state_d = RESP;
          // Stores return no data; their completion clears d_rdata.
          if (owner_i_q)       i_rdata_d = m_rdata;
          else if (owner_st_q) d_rdata_d = '0;
          else                 d_rdata_d = m_rdata;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_i) begin
      d_run_d = '0;
    end else if (grant_d) begin
      if (!i_req)                d_run_d = '0;
      else if (d_run_q != RUN_MAX) d_run_d = d_run_q + 1'b1;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      lat_cnt_q  <= '0;
      d_run_q    <= '0;
      owner_i_q  <= 1'b0;
      owner_st_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      d_run_q    <= d_run_d;
      owner_i_q  <= owner_i_d;
      owner_st_q <= owner_st_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign i_gnt    = grant_i;
  assign d_gnt    = grant_d;
  assign m_en     = grant_i || grant_d;
  assign m_we     = grant_d ? (d_be & {4{d_we}}) : 4'b0000;
  assign m_addr   = grant_d ? d_addr[ADDR_W+1:2] : (grant_i ? i_addr[ADDR_W+1:2] : '0);
  assign m_wdata  = grant_d ? d_wdata : 32'd0;
  assign i_rvalid = rst && (state_q == RESP) && owner_i_q;
  assign d_rvalid = rst && (state_q == RESP) && !owner_i_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign stall    = rst && ((i_req && !grant_i) || (d_req && !grant_d) || (state_q == WAIT));

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int ADDR_W    = 14;
  localparam int MEM_LAT   = 2;
  localparam int MAX_D_RUN = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req, i_gnt, i_rvalid;
  logic [31:0]       i_addr, i_rdata;
  logic              d_req, d_we, d_gnt, d_rvalid;
  logic [31:0]       d_addr, d_wdata, d_rdata;
  logic [3:0]        d_be;
  logic              m_en;
  logic [3:0]        m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata, m_rdata;
  logic              stall;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .MAX_D_RUN(MAX_D_RUN)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .stall(stall)
  );

  typedef struct {
    bit          is_i;
    logic [31:0] data;
    int          due;
  } resp_t;

  typedef struct {
    int idx;
    int due;
  } rd_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  resp_t       expq[$];
  rd_t         pend[$];
  logic [31:0] ref_mem[16];
  logic [31:0] mem[16];
  int          next_free = 0;
  int          d_run = 0;
  bit          eg_i = 0, eg_d = 0;
  logic [31:0] hold_i = 0, hold_d = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Memory responder: applies DUT writes and returns the addressed word exactly MEM_LAT cycles after issue.
  always @(posedge clk) begin
    if (m_en === 1'b1) begin
      rd_t r;
      r.idx = int'(m_addr[3:0]);
      r.due = cyc + MEM_LAT;
      for (int b = 0; b < 4; b++)
        if (m_we[b]) mem[r.idx][8*b +: 8] = m_wdata[8*b +: 8];
      pend.push_back(r);
    end
    cyc++;
    #1;
    while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
    if (pend.size() > 0 && pend[0].due == cyc) m_rdata = mem[pend[0].idx];
    else                                       m_rdata = $urandom;
  end

  // Reference model: slot-level arbiter (busy until issue+MEM_LAT+1) plus a word-array memory.
  always @(negedge clk) begin
    bit          gi, gd, free, busy;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_we;
    resp_t       r;
    int          w;
    gi = 0; gd = 0;
    busy = cyc < next_free;
    free = (rst === 1'b1) && !busy;
    if (free) begin
      if (i_req && d_req) begin
        if (d_run >= MAX_D_RUN) gi = 1; else gd = 1;
      end else begin
        gi = i_req;
        gd = d_req;
      end
    end
    e_addr  = gd ? ((d_addr >> 2) % (1 << ADDR_W)) : gi ? ((i_addr >> 2) % (1 << ADDR_W)) : 0;
    e_we    = (gd && d_we) ? d_be : 4'h0;
    e_wdata = gd ? d_wdata : 0;
    check("i_gnt", i_gnt, gi);
    check("d_gnt", d_gnt, gd);
    check("m_en", m_en, gi | gd);
    check("m_we", m_we, e_we);
    check("m_addr", m_addr, e_addr);
    check("m_wdata", m_wdata, e_wdata);
    check("stall", stall, rst && ((i_req && !gi) || (d_req && !gd) || busy));
    if (!rst) begin
      check("i_rvalid_rst", i_rvalid, 0);
      check("d_rvalid_rst", d_rvalid, 0);
      next_free = 0;
      d_run = 0;
      expq.delete();
    end else if (gi || gd) begin
      next_free = cyc + MEM_LAT + 1;
      r.is_i = gi;
      r.due  = cyc + MEM_LAT + 1;
      w = gi ? int'(i_addr[5:2]) : int'(d_addr[5:2]);
      if (gd && d_we) begin
        r.data = 0;
        for (int b = 0; b < 4; b++)
          if (d_be[b]) ref_mem[w][8*b +: 8] = d_wdata[8*b +: 8];
      end else begin
        r.data = ref_mem[w];
      end
      expq.push_back(r);
      if (gi)          d_run = 0;
      else if (i_req)  d_run = (d_run < MAX_D_RUN) ? d_run + 1 : d_run;
      else             d_run = 0;
    end
    eg_i = gi;
    eg_d = gd;
  end

  // Monitor: pops the scoreboard whenever the DUT presents a response and checks owner, timing, data.
  always @(negedge clk) begin
    resp_t e;
    #1;
    if (rst === 1'b1) begin
      if (i_rvalid && d_rvalid) check("dual_rvalid", 1, 0);
      if (i_rvalid || d_rvalid) begin
        if (expq.size() == 0) begin
          check("unexpected_rvalid", {i_rvalid, d_rvalid}, 0);
        end else begin
          e = expq.pop_front();
          check("rsp_owner", i_rvalid, e.is_i);
          check("rsp_cycle", cyc, e.due);
          if (e.is_i) hold_i = e.data;
          else        hold_d = e.data;
        end
      end else if (expq.size() > 0 && expq[0].due <= cyc) begin
        e = expq.pop_front();
        check("missing_rvalid", 0, 1);
      end
      check("i_rdata", i_rdata, hold_i);
      check("d_rdata", d_rdata, hold_d);
    end else begin
      hold_i = 0;
      hold_d = 0;
    end
  end

  task automatic run_phase(int cycles, int p_req, int p_rst);
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(99) < p_rst) ? 1'b0 : 1'b1;
      if (i_req && !eg_i) begin
        if ($urandom_range(99) < 2) i_req = 1'b0;
      end else begin
        i_req  = ($urandom_range(99) < p_req);
        i_addr = $urandom;
      end
      if (d_req && !eg_d) begin
        if ($urandom_range(99) < 2) d_req = 1'b0;
      end else begin
        d_req   = ($urandom_range(99) < p_req);
        d_addr  = $urandom;
        d_we    = $urandom_range(1);
        d_be    = 4'($urandom_range(15));
        d_wdata = $urandom;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin
      ref_mem[k] = 32'hA5A5_0000 ^ (k * 32'h0101_0101);
      mem[k]     = 32'hA5A5_0000 ^ (k * 32'h0101_0101);
    end
    rst     = 1'b0;
    i_req   = 1'b1;
    i_addr  = 32'h0000_0010;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h0000_0020;
    d_wdata = 32'h1234_5678;
    d_be    = 4'b0011;
    m_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    run_phase(400, 95, 0);
    run_phase(400, 40, 0);
    run_phase(800, 60, 3);
    @(posedge clk);
    #1;
    rst   = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (MEM_LAT + 4) @(posedge clk);
    #3;
    check("drain_empty", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported, non-pipelined synchronous memory between the instruction-fetch requester (I) and the load/store requester (D) of the 3-stage pipeline.
- Allows one outstanding transaction at a time.
- Arbitrates between I and D, with D having priority and a bounded-starvation guarantee for I.
- Routes the memory response back to the requester that issued the transaction.
- Generates the pipeline stall signal.

Parameters:
- ADDR_W, 14: memory word-address width. m_addr = addr[ADDR_W+1:2].
- MEM_LAT, 2: cycles from the issue cycle (m_en=1) to m_rdata valid. Must be >= 1.
- MAX_D_RUN, 2: maximum consecutive D grants while i_req is pending before I must be granted. Must be >= 1.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-low (rst=0 resets)
- i_req  in  1  fetch request; held high until i_gnt
- i_addr  in  32  fetch byte address
- i_gnt  out  1  one-cycle pulse; i_addr sampled this cycle
- i_rvalid  out  1  one-cycle pulse; i_rdata valid
- i_rdata  out  32  fetch read data
- d_req  in  1  data request; held high until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_be  in  4  store byte enables
- d_gnt  out  1  one-cycle pulse; D inputs sampled this cycle
- d_rvalid  out  1  one-cycle pulse; load data valid or store complete
- d_rdata  out  32  load data (0 for stores)
- m_en  out  1  memory enable, high in issue cycle only
- m_we  out  4  byte write enables (d_be & {4{d_we}} for D; 0 for I)
- m_addr  out  ADDR_W  word address
- m_wdata  out  32  write data
- m_rdata  in  32  memory read data, valid MEM_LAT cycles after issue
- stall  out  1  pipeline stall

Behaviour:
- FSM states:
  - IDLE: no outstanding transaction.
  - WAIT: a transaction is outstanding. A down-counter lat_cnt is loaded with MEM_LAT-1 at issue.
  - RESP: m_rdata has been captured into a register. rvalid is high for the owner.
- Transitions:
  - IDLE or RESP, with any request: issue, go to WAIT.
  - IDLE, no request: stay in IDLE.
  - RESP, no request: go to IDLE.
  - WAIT with lat_cnt == 0: capture m_rdata, go to RESP.
  - WAIT otherwise: decrement lat_cnt.
- Issue is combinational in IDLE/RESP: gnt, m_en, m_we, m_addr and m_wdata are all driven in the same cycle as the winning req. The owner bit is registered.
- Timing: issue at cycle T; rvalid and rdata at T+MEM_LAT+1. A new issue is allowed in the rvalid cycle, so throughput is one transaction per MEM_LAT+1 cycles.
- Arbitration when free:
  - Only one requester: it wins.
  - Both requesting: D wins unless d_run == MAX_D_RUN, in which case I wins.
- d_run counter:
  - Increments, saturating, on a D grant while i_req=1.
  - Clears on an I grant, and on a D grant while i_req=0.
- Stores: m_we = d_be. d_rvalid pulses at T+MEM_LAT+1 as the completion ack, with d_rdata=0.
- m_rdata is captured only for loads and fetches.
- rdata outputs hold their last value outside rvalid. Both are 0 after reset.
- When not issuing, m_en=0, m_we=0, m_addr=0 and m_wdata=0.
- stall = (i_req & ~i_gnt) | (d_req & ~d_gnt) | (state==WAIT).
- Reset (rst=0 on any clock edge, including mid-transaction):
  - state goes to IDLE; outstanding transaction dropped, no rvalid issued for it.
  - d_run=0, lat_cnt=0, rdata registers=0.
  - All outputs 0 during reset: gnts, rvalids, m_en, m_we, m_addr, m_wdata, stall.
  - Requests are ignored during reset.
- Requests asserted while busy are not granted and keep stall high.
- A req dropped before its gnt is not an error: no transaction is issued.

Test Plan:
- Reset: rst=0 for 3 cycles with i_req=d_req=1 -> all outputs 0. First cycle with rst=1 -> d_gnt=1, i_gnt=0.
- Fetch read (MEM_LAT=2): i_req=1, i_addr=0x0000_0010 at T -> i_gnt=1, m_en=1, m_addr=0x0004, m_we=0 at T. Drive m_rdata=0xDEADBEEF at T+2 -> i_rvalid=1, i_rdata=0xDEADBEEF at T+3. stall=1 during T+1..T+2.
- Store: d_we=1, d_addr=0x20, d_be=4'b0011, d_wdata=0x12345678 -> m_we=4'b0011, m_addr=0x0008, m_wdata=0x12345678 at issue. d_rvalid=1, d_rdata=0 at T+3. i_rvalid stays 0.
- Starvation (MAX_D_RUN=2): i_req and d_req held high for 4 transactions -> grant order D, D, I, D. Issue cycles are T, T+3, T+6, T+9.
- Reset mid-op: issue a D load at T, rst=0 at T+1 for 1 cycle -> no d_rvalid at T+3. The next request is granted in the first cycle after rst=1.
- Back-to-back: d_req held for two loads -> the second d_gnt coincides with the first d_rvalid. stall=0 only in cycles where a held request is granted.
